// File: rtl/mc_pkg.sv
// Purpose: shared constants for the multicycle MIPS-subset control unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mc_pkg;

    // FSM state encodings, also exported on the debug state port
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;

    // Opcodes
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function fields
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    // Internal ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Purpose: maps aluop + funct to the 4-bit ALU control code; flags recognised functs.
// Latency: purely combinational.
// Backpressure: none.
// Ports: aluop/funct in; alucontrol code and funct_valid out.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] alucontrol,
    output logic       funct_valid
);

    always_comb begin
        alucontrol  = ALU_ADD;
        funct_valid = 1'b0;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                funct_valid = 1'b1;
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    F_SLL:   alucontrol = ALU_SLL;
                    // Unknown funct falls back to add so the ALU does something benign
                    default: begin
                        alucontrol  = ALU_ADD;
                        funct_valid = 1'b0;
                    end
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Purpose: Moore FSM sequencing the multicycle MIPS-subset datapath, one instruction at a time.
// Latency: outputs combinational from state; 2-5 cycles per instruction plus memory stalls.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; other states advance unconditionally.
// Ports: clk, reset_n; op/funct/zero/mem_ready in; datapath mux selects, write strobes,
//        alucontrol and debug state out.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [3:0] alucontrol,
    output logic [3:0] state
);

    logic [3:0] next_state;
    logic [1:0] aluop;
    logic       funct_valid;
    logic       pcwrite;
    logic       branch;
    logic       ir_we;
    logic       mem_we;
    logic       rf_we;

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (funct),
        .alucontrol  (alucontrol),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        iord       = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        rf_we      = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alusrcb = 2'b01;
                ir_we   = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target PC+4+(imm<<2) is precomputed here into ALUOut
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                rf_we      = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                iord   = 1'b1;
                mem_we = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = funct_valid ? S_RTYPEWB : S_FETCH;
            end
            S_RTYPEWB: begin
                // Keep funct decode so alucontrol stays stable across writeback
                regdst     = 1'b1;
                rf_we      = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we      = 1'b1;
                next_state = S_FETCH;
            end
            S_JEX: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // State-changing strobes are suppressed while reset is held so nothing
    // architectural moves even though FETCH would otherwise assert them
    assign irwrite  = ir_we  & reset_n;
    assign memwrite = mem_we & reset_n;
    assign regwrite = rf_we  & reset_n;
    assign pcen     = (pcwrite | (branch & zero)) & reset_n;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
    localparam int RTYPEEX = 6, RTYPEWB = 7, BEQEX = 8, ADDIEX = 9, ADDIWB = 10, JEX = 11;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol, state;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .state      (state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [3:0] aluc;
    } obs_t;

    typedef struct packed {
        obs_t o;
        logic aluc_chk;
    } exp_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       mr;
    } stim_t;

    stim_t pst[$];
    exp_t  pex[$];
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    // {recognised, alucontrol} for an R-type funct
    function automatic logic [4:0] rfunc(logic [5:0] f);
        case (f)
            6'b100000: return 5'b1_0010;
            6'b100010: return 5'b1_0110;
            6'b100100: return 5'b1_0000;
            6'b100101: return 5'b1_0001;
            6'b101010: return 5'b1_0111;
            6'b000000: return 5'b1_1000;
            default:   return 5'b0_0010;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected outputs of one cycle spent in state st
    function automatic exp_t exp_of(int st, logic mr, logic z, logic [5:0] f);
        exp_t       e;
        logic [4:0] r;
        e      = '0;
        r      = rfunc(f);
        e.o.st = 4'(st);
        case (st)
            FETCH:   begin e.o.srcb = 2'b01; e.o.aluc = 4'b0010; e.aluc_chk = 1'b1;
                           e.o.irwrite = mr; e.o.pcen = mr; end
            DECODE:  begin e.o.srcb = 2'b11; e.o.aluc = 4'b0010; e.aluc_chk = 1'b1; end
            MEMADR:  begin e.o.alusrca = 1'b1; e.o.srcb = 2'b10; e.o.aluc = 4'b0010; e.aluc_chk = 1'b1; end
            MEMRD:   e.o.iord = 1'b1;
            MEMWB:   begin e.o.memtoreg = 1'b1; e.o.regwrite = 1'b1; end
            MEMWR:   begin e.o.iord = 1'b1; e.o.memwrite = 1'b1; end
            RTYPEEX: begin e.o.alusrca = 1'b1; e.o.aluc = r[3:0]; e.aluc_chk = 1'b1; end
            RTYPEWB: begin e.o.regdst = 1'b1; e.o.regwrite = 1'b1; e.o.aluc = r[3:0]; e.aluc_chk = 1'b1; end
            BEQEX:   begin e.o.alusrca = 1'b1; e.o.aluc = 4'b0110; e.aluc_chk = 1'b1;
                           e.o.pcsrc = 2'b01; e.o.pcen = z; end
            ADDIEX:  begin e.o.alusrca = 1'b1; e.o.srcb = 2'b10; e.o.aluc = 4'b0010; e.aluc_chk = 1'b1; end
            ADDIWB:  e.o.regwrite = 1'b1;
            JEX:     begin e.o.pcsrc = 2'b10; e.o.pcen = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(int st, logic [5:0] o, logic [5:0] f, logic z, logic mr);
        stim_t s;
        s.op = o; s.funct = f; s.zero = z; s.mr = mr;
        pst.push_back(s);
        pex.push_back(exp_of(st, mr, z, f));
    endtask

    // Expand one instruction into its expected per-cycle state walk
    task automatic plan_instr(logic [5:0] o, logic [5:0] f, logic z, int fs, int ms);
        logic [4:0] r;
        r = rfunc(f);
        for (int i = 0; i < fs; i++) step(FETCH, o, f, rb(), 1'b0);
        step(FETCH, o, f, rb(), 1'b1);
        step(DECODE, o, f, rb(), rb());
        case (o)
            LW: begin
                step(MEMADR, o, f, rb(), rb());
                for (int i = 0; i < ms; i++) step(MEMRD, o, f, rb(), 1'b0);
                step(MEMRD, o, f, rb(), 1'b1);
                step(MEMWB, o, f, rb(), rb());
            end
            SW: begin
                step(MEMADR, o, f, rb(), rb());
                for (int i = 0; i < ms; i++) step(MEMWR, o, f, rb(), 1'b0);
                step(MEMWR, o, f, rb(), 1'b1);
            end
            RT: begin
                step(RTYPEEX, o, f, rb(), rb());
                if (r[4]) step(RTYPEWB, o, f, rb(), rb());
            end
            BEQ:  step(BEQEX, o, f, z, rb());
            ADDI: begin
                step(ADDIEX, o, f, rb(), rb());
                step(ADDIWB, o, f, rb(), rb());
            end
            JMP:  step(JEX, o, f, rb(), rb());
            default: ;
        endcase
    endtask

    // Drive up to n planned cycles (all when n < 0); called at posedge+1
    task automatic run_plan(int n);
        int k;
        k = 0;
        while (pst.size() > 0 && (n < 0 || k < n)) begin
            stim_t s;
            s         = pst.pop_front();
            op        = s.op;
            funct     = s.funct;
            zero      = s.zero;
            mem_ready = s.mr;
            sb.push_back(pex.pop_front());
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    // One cycle held in reset: FETCH values with the strobes forced low
    task automatic rst_cycle();
        exp_t e;
        op        = LW;
        funct     = 6'b000000;
        zero      = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || irwrite !== 1'b0 || pcen !== 1'b0 ||
            memwrite !== 1'b0 || regwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_state t=%0t st=%0d irw=%0b pcen=%0b mw=%0b rw=%0b",
                     $time, state, irwrite, pcen, memwrite, regwrite);
        end
        e         = exp_of(FETCH, 1'b1, 1'b1, 6'b000000);
        e.o.irwrite = 1'b0;
        e.o.pcen    = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with a pending expectation is compared at the falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            obs_t a;
            e          = sb.pop_front();
            a.st       = state;
            a.iord     = iord;
            a.memwrite = memwrite;
            a.irwrite  = irwrite;
            a.regdst   = regdst;
            a.memtoreg = memtoreg;
            a.regwrite = regwrite;
            a.alusrca  = alusrca;
            a.srcb     = alusrcb;
            a.pcsrc    = pcsrc;
            a.pcen     = pcen;
            a.aluc     = e.aluc_chk ? alucontrol : e.o.aluc;
            checks++;
            if (a !== e.o) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t rst_n=%0b got st=%0d iord=%0b mw=%0b irw=%0b rd=%0b m2r=%0b rw=%0b sa=%0b sb=%0b pcs=%0b pcen=%0b aluc=%0b ; want st=%0d iord=%0b mw=%0b irw=%0b rd=%0b m2r=%0b rw=%0b sa=%0b sb=%0b pcs=%0b pcen=%0b aluc=%0b",
                         $time, reset_n, a.st, a.iord, a.memwrite, a.irwrite, a.regdst, a.memtoreg,
                         a.regwrite, a.alusrca, a.srcb, a.pcsrc, a.pcen, a.aluc,
                         e.o.st, e.o.iord, e.o.memwrite, e.o.irwrite, e.o.regdst, e.o.memtoreg,
                         e.o.regwrite, e.o.alusrca, e.o.srcb, e.o.pcsrc, e.o.pcen, e.o.aluc);
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout t=%0t: simulation did not complete, %0d checks, %0d errors",
                 $time, checks, errors);
        $finish;
    end

    initial begin
        logic [5:0] ops[7];
        logic [5:0] fns[7];
        ops = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};

        reset_n   = 1'b0;
        op        = LW;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Held in reset with mem_ready high: strobes must stay low
        rst_cycle();
        rst_cycle();
        reset_n = 1'b1;

        // lw that gets aborted by reset while stalled in MEMRD
        plan_instr(LW, 6'b000000, 1'b0, 0, 5);
        run_plan(5);
        reset_n = 1'b0;
        pst.delete();
        pex.delete();
        rst_cycle();
        rst_cycle();
        reset_n = 1'b1;

        // Directed cases
        plan_instr(LW,   6'b000000, 1'b0, 0, 0);
        plan_instr(SW,   6'b000000, 1'b0, 0, 3);
        plan_instr(RT,   6'b000000, 1'b0, 0, 0);
        plan_instr(RT,   6'b101010, 1'b0, 0, 0);
        plan_instr(RT,   6'b111111, 1'b0, 0, 0);
        plan_instr(RT,   6'b100010, 1'b0, 1, 0);
        plan_instr(BEQ,  6'b000000, 1'b1, 0, 0);
        plan_instr(BEQ,  6'b000000, 1'b0, 0, 0);
        plan_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        plan_instr(JMP,  6'b000000, 1'b0, 0, 0);
        plan_instr(ADDI, 6'b000000, 1'b0, 2, 0);
        plan_instr(LW,   6'b000000, 1'b0, 1, 2);
        run_plan(-1);

        // Randomised instruction mix with random stalls
        for (int i = 0; i < 200; i++) begin
            logic [5:0] o, f;
            o = ops[$urandom_range(0, 6)];
            if (o == 6'b111111) o = 6'($urandom_range(0, 63));
            f = fns[$urandom_range(0, 6)];
            if (f == 6'b111111) f = 6'($urandom_range(0, 63));
            plan_instr(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
            run_plan(-1);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
